i2c_slave: RTL and testbench

- 7-bit-address I2C target (responder) for the same bus that our i2c_master drives.
- Oversamples SCL/SDA on the system clock and detects START and STOP conditions.
- Decodes the address byte, ACKs on a match, then receives bytes onto a valid/ready stream (master write) or transmits bytes from a load interface (master read).
- SDA is open-drain: the block only pulls low via sda_oe.

---
 rtl/i2c_slave.sv | 180 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// 7-bit-address I2C target: oversampled SCL/SDA, START/STOP detection,
// write bytes onto a valid/ready stream, read bytes from a load interface.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_taken,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_q, sda_q, scl_prev, sda_prev;
  logic                   scl_rise, scl_fall, start_det, stop_det;
  logic [2:0]             bit_cnt;
  logic [6:0]             shift;
  logic [6:0]             tx_shift;
  logic                   rw, byte_done, ack_ok;

  // Synchronizers reset to the idle-bus level so reset release makes no false edges
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_i};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_i};
      scl_prev <= scl_q;
      sda_prev <= sda_q;
    end
  end

  assign scl_q     = scl_sync[SYNC_STAGES-1];
  assign sda_q     = sda_sync[SYNC_STAGES-1];
  assign scl_rise  = scl_q & ~scl_prev;
  assign scl_fall  = ~scl_q & scl_prev;
  assign start_det = scl_q & sda_prev & ~sda_q;
  assign stop_det  = scl_q & ~sda_prev & sda_q;
  assign busy      = (state != IDLE);

  // byte_done marks "byte finished on scl_rise, act on the following scl_fall"
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift     <= 7'd0;
      tx_shift  <= 7'd0;
      rw        <= 1'b0;
      byte_done <= 1'b0;
      ack_ok    <= 1'b0;
      sda_oe    <= 1'b0;
      rx_data   <= 8'd0;
      rx_valid  <= 1'b0;
      tx_taken  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      tx_taken <= 1'b0;
      if (start_det) begin
        state     <= ADDR;
        bit_cnt   <= 3'd0;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else if (stop_det) begin
        state     <= IDLE;
        byte_done <= 1'b0;
        sda_oe    <= 1'b0;
      end else begin
        case (state)
          IDLE: sda_oe <= 1'b0;
          ADDR: begin
            if (scl_rise && !byte_done) begin
              shift   <= {shift[5:0], sda_q};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (shift == SLAVE_ADDR) begin
                  rw        <= sda_q;
                  byte_done <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              sda_oe    <= 1'b1;
              state     <= ADDR_ACK;
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              if (rw) begin
                tx_shift <= tx_data[6:0];
                tx_taken <= 1'b1;
                sda_oe   <= ~tx_data[7];
                bit_cnt  <= 3'd0;
                state    <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end
          WR_DATA: begin
            if (scl_rise && !byte_done) begin
              shift   <= {shift[5:0], sda_q};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                rx_data   <= {shift, sda_q};
                rx_valid  <= 1'b1;
                ack_ok    <= rx_ready;
                byte_done <= 1'b1;
              end
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              if (ack_ok) begin
                sda_oe <= 1'b1;
                state  <= WR_ACK;
              end else begin
                state <= WAIT_STOP;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= WR_DATA;
            end
          end
          // Bit 7 is already on the bus on entry; each fall moves to the next bit
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= RD_ACK;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          RD_ACK: begin
            if (scl_rise && !byte_done) begin
              if (sda_q) state <= WAIT_STOP;
              else       byte_done <= 1'b1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              tx_shift  <= tx_data[6:0];
              tx_taken  <= 1'b1;
              sda_oe    <= ~tx_data[7];
              state     <= RD_DATA;
            end
          end
          WAIT_STOP: sda_oe <= 1'b0;
          default: begin
            sda_oe <= 1'b0;
            state  <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master drives the bus, a transaction-level
// model predicts ACKs, received bytes, read-back bytes and pulse counts.
module tb_i2c_slave;

  localparam int         SYNC = 2;
  localparam int         Q    = 8;
  localparam logic [6:0] ADDR = 7'h50;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m = 1'b1;
  logic       rx_ready = 1'b1;
  logic       sda_bus, sda_oe, rx_valid, tx_taken, busy;
  logic [7:0] rx_data, tx_data;

  logic [7:0] tx_arr [8];
  logic [7:0] wr_data [8];
  logic       wr_ready [8];
  int         tx_base = 0;
  int         total = 0, bad = 0, contention = 0;
  int         cyc = 0, rise_cyc = 0, rx_cnt = 0, tx_cnt = 0, oe_cyc = 0;
  logic [7:0] rx_seen[$];
  int         lat_q[$];

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low
  assign sda_bus = sda_m & ~sda_oe;
  assign tx_data = tx_arr[3'(tx_cnt - tx_base)];

  i2c_slave #(.SLAVE_ADDR(ADDR), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .scl_i(scl), .sda_i(sda_bus), .sda_oe(sda_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_taken(tx_taken), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge scl) rise_cyc = cyc;

  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      rx_seen.push_back(rx_data);
      lat_q.push_back(cyc - rise_cyc);
    end
    if (tx_taken) tx_cnt++;
    if (sda_oe) oe_cyc++;
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clks(Q);
    scl = 1'b1;   wait_clks(Q);
    sda_m = 1'b0; wait_clks(Q);
    scl = 1'b0;   wait_clks(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clks(Q);
    scl = 1'b1;   wait_clks(Q);
    sda_m = 1'b1; wait_clks(Q);
  endtask

  task automatic write_bit(input logic v);
    sda_m = v;  wait_clks(Q);
    scl = 1'b1; wait_clks(Q);
    if (sda_oe) contention++;
    wait_clks(Q);
    scl = 1'b0; wait_clks(Q);
  endtask

  task automatic read_bit(output logic v);
    sda_m = 1'b1; wait_clks(Q);
    scl = 1'b1;   wait_clks(Q);
    v = sda_bus;  wait_clks(Q);
    scl = 1'b0;   wait_clks(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output bit ack);
    logic v;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(v);
    ack = !v;
  endtask

  task automatic read_byte(output logic [7:0] b, input bit ack);
    logic v;
    for (int i = 7; i >= 0; i--) begin
      read_bit(v);
      b[i] = v;
    end
    write_bit(!ack);
  endtask

  // Model: a byte is received while the transfer is still live; a NACK kills the rest
  task automatic apply_write(input logic [7:0] ab, input int n, input string tag);
    bit ack, live;
    int rx0, oe0, lat0, rxb;
    logic [7:0] exp_q[$];
    rx0 = rx_cnt; oe0 = oe_cyc; lat0 = lat_q.size(); rxb = rx_seen.size();
    contention = 0;
    live = (ab[7:1] == ADDR) && !ab[0];
    i2c_start();
    write_byte(ab, ack);
    check_output($sformatf("%s_addr_ack", tag), 32'(ack), 32'(live));
    for (int i = 0; i < n; i++) begin
      rx_ready = wr_ready[i];
      write_byte(wr_data[i], ack);
      if (live) exp_q.push_back(wr_data[i]);
      live = live && wr_ready[i];
      check_output($sformatf("%s_d%0d_ack", tag, i), 32'(ack), 32'(live));
    end
    check_output($sformatf("%s_busy_pre_stop", tag), 32'(busy), 32'd1);
    i2c_stop();
    wait_clks(4);
    check_output($sformatf("%s_busy_post_stop", tag), 32'(busy), 32'd0);
    check_output($sformatf("%s_rx_count", tag), 32'(rx_cnt - rx0), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (rxb + i < rx_seen.size())
        check_output($sformatf("%s_rx%0d", tag, i), 32'(rx_seen[rxb + i]), 32'(exp_q[i]));
    for (int i = lat0; i < lat_q.size(); i++)
      check_output($sformatf("%s_rx_latency", tag), 32'(lat_q[i]), 32'(SYNC + 1));
    check_output($sformatf("%s_contention", tag), 32'(contention), 32'd0);
    if (ab[7:1] != ADDR)
      check_output($sformatf("%s_never_drives", tag), 32'(oe_cyc - oe0), 32'd0);
  endtask

  // Model: a matching read returns tx_arr in order; otherwise the bus reads idle-high
  task automatic apply_read(input logic [7:0] ab, input int n, input string tag);
    bit ack, hit;
    logic [7:0] b;
    tx_base = tx_cnt;
    contention = 0;
    hit = (ab[7:1] == ADDR) && ab[0];
    i2c_start();
    write_byte(ab, ack);
    check_output($sformatf("%s_addr_ack", tag), 32'(ack), 32'(hit));
    for (int i = 0; i < n; i++) begin
      read_byte(b, i < n - 1);
      check_output($sformatf("%s_byte%0d", tag, i), 32'(b), hit ? 32'(tx_arr[i]) : 32'hFF);
    end
    check_output($sformatf("%s_released_after_nack", tag), 32'(sda_oe), 32'd0);
    check_output($sformatf("%s_busy_pre_stop", tag), 32'(busy), 32'd1);
    i2c_stop();
    wait_clks(4);
    check_output($sformatf("%s_tx_taken_count", tag), 32'(tx_cnt - tx_base), hit ? 32'(n) : 32'd0);
    check_output($sformatf("%s_contention", tag), 32'(contention), 32'd0);
    check_output($sformatf("%s_busy_post_stop", tag), 32'(busy), 32'd0);
  endtask

  initial begin
    bit         ack, rw;
    logic       v;
    logic [7:0] b;
    logic [6:0] a;
    int         rx0, n;

    for (int i = 0; i < 8; i++) begin
      tx_arr[i] = 8'h00; wr_data[i] = 8'h00; wr_ready[i] = 1'b1;
    end
    wait_clks(5);
    check_output("reset_sda_oe", 32'(sda_oe), 32'd0);
    check_output("reset_rx_data", 32'(rx_data), 32'd0);
    check_output("reset_rx_valid", 32'(rx_valid), 32'd0);
    check_output("reset_tx_taken", 32'(tx_taken), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    wait_clks(Q);
    check_output("idle_busy", 32'(busy), 32'd0);

    $display("[TB] basic write");
    wr_data[0] = 8'h3C; wr_ready[0] = 1'b1;
    apply_write(8'hA0, 1, "wr_basic");

    $display("[TB] foreign address");
    wr_data[0] = 8'($urandom); wr_data[1] = 8'($urandom);
    wr_ready[0] = 1'b1; wr_ready[1] = 1'b1;
    apply_write(8'hA2, 2, "wr_other");

    $display("[TB] basic read");
    tx_arr[0] = 8'hA5; tx_arr[1] = 8'h5A;
    apply_read(8'hA1, 2, "rd_basic");

    $display("[TB] write with NACK on second byte");
    wr_data[0] = 8'($urandom); wr_data[1] = 8'($urandom);
    wr_ready[0] = 1'b1; wr_ready[1] = 1'b0;
    apply_write(8'hA0, 2, "wr_nack");
    rx_ready = 1'b1;

    $display("[TB] repeated START");
    rx0 = rx_cnt; tx_base = tx_cnt; contention = 0;
    tx_arr[0] = 8'($urandom);
    i2c_start();
    write_byte(8'hA0, ack);
    check_output("rs_wr_addr_ack", 32'(ack), 32'd1);
    for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
    i2c_start();
    check_output("rs_sda_oe_at_start", 32'(sda_oe), 32'd0);
    write_byte(8'hA1, ack);
    check_output("rs_rd_addr_ack", 32'(ack), 32'd1);
    read_byte(b, 1'b0);
    check_output("rs_rd_byte", 32'(b), 32'(tx_arr[0]));
    i2c_stop();
    wait_clks(4);
    check_output("rs_no_rx_valid", 32'(rx_cnt - rx0), 32'd0);
    check_output("rs_tx_taken", 32'(tx_cnt - tx_base), 32'd1);
    check_output("rs_contention", 32'(contention), 32'd0);

    $display("[TB] reset during read bit 0");
    tx_base = tx_cnt;
    tx_arr[0] = {7'($urandom), 1'b0};
    i2c_start();
    write_byte(8'hA1, ack);
    for (int i = 0; i < 7; i++) read_bit(v);
    check_output("rst_bit0_driven", 32'(sda_oe), 32'd1);
    rst = 1'b1;
    #1;
    check_output("rst_sda_oe", 32'(sda_oe), 32'd0);
    check_output("rst_rx_data", 32'(rx_data), 32'd0);
    check_output("rst_rx_valid", 32'(rx_valid), 32'd0);
    check_output("rst_tx_taken", 32'(tx_taken), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    wait_clks(2);
    scl = 1'b1; sda_m = 1'b1;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(Q);
    wr_data[0] = 8'($urandom); wr_ready[0] = 1'b1;
    apply_write(8'hA0, 1, "post_rst");

    $display("[TB] randomized transactions");
    for (int k = 0; k < 6; k++) begin
      rw = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 3) == 0) ? 7'($urandom) : ADDR;
      n  = $urandom_range(1, 3);
      for (int i = 0; i < 8; i++) begin
        tx_arr[i]   = 8'($urandom);
        wr_data[i]  = 8'($urandom);
        wr_ready[i] = ($urandom_range(0, 3) != 0);
      end
      if (rw) apply_read({a, 1'b1}, n, $sformatf("rnd%0d_rd", k));
      else    apply_write({a, 1'b0}, n, $sformatf("rnd%0d_wr", k));
      rx_ready = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
